irq_pending_ctrl: RTL and testbench

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_prio_enc.sv | 19 +
 rtl/irq_pending_ctrl.sv | 100 ++++++++++
 tb/tb_irq_pending_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared sizes and FSM state encoding for the interrupt pending controller.
package irq_pkg;

  localparam int unsigned N_SRC = 8;
  localparam int unsigned VEC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_RELEASE = 2'b10
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational highest-index-wins priority encoder.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  output logic [VEC_W-1:0] idx_o,
  output logic             valid_o
);

  // Ascending scan: the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req_i[i]) idx_o = VEC_W'(i);
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Synchronises async interrupt lines, latches rising edges as sticky pending
// bits and presents the highest-priority unmasked source over a 4-phase handshake.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_SRC-1:0] pending
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] dly_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] sel;
  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] win_idx;
  logic             win_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign sel  = pend_q & mask;

  irq_prio_enc u_prio (
    .req_i   (sel),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          vec_d   = win_idx;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          clr     = N_SRC'(1) << vec_q;
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!irq_ack) state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // A fresh rise on the bit being serviced survives the clear.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      vec_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      pend_q  <= pend_d;
    end
  end

  assign irq_req = req_q;
  assign irq_vec = vec_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed vector table, reset
// corner cases and randomized traffic against a behavioural reference model.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_req;
  logic [2:0] irq_vec;
  logic [7:0] pending;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .mask    (mask),
    .irq_ack (irq_ack),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .pending (pending)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: input history by edge, pending set, handshake flags.
  logic [7:0] m_in_prev1, m_in_prev2, m_in_prev3;
  logic [7:0] m_pend;
  logic       m_presenting, m_wait_release;
  logic [2:0] m_vec;

  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_in_prev1 = '0; m_in_prev2 = '0; m_in_prev3 = '0;
    m_pend = '0; m_presenting = 1'b0; m_wait_release = 1'b0; m_vec = '0;
  endtask

  task automatic model_edge();
    logic [7:0] ev;
    logic [7:0] cleared;
    if (!rst_n) begin
      model_reset();
    end else begin
      // Line seen high two edges ago but low three edges ago = new event now.
      ev      = m_in_prev2 & ~m_in_prev3;
      cleared = '0;
      if (m_presenting) begin
        if (irq_ack) begin
          cleared[m_vec] = 1'b1;
          m_presenting   = 1'b0;
          m_wait_release = 1'b1;
        end
      end else if (m_wait_release) begin
        if (!irq_ack) m_wait_release = 1'b0;
      end else if ((m_pend & mask) != 8'h00) begin
        m_vec        = 3'(top_bit(m_pend & mask));
        m_presenting = 1'b1;
      end
      m_pend     = (m_pend & ~cleared) | ev;
      m_in_prev3 = m_in_prev2;
      m_in_prev2 = m_in_prev1;
      m_in_prev1 = irq_in;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_req"},  {7'd0, irq_req}, {7'd0, m_presenting});
    chk({tag, "_vec"},  {5'd0, irq_vec}, {5'd0, m_vec});
    chk({tag, "_pend"}, pending, m_pend);
  endtask

  task automatic cyc(input logic [7:0] in_v, input logic [7:0] mask_v, input logic ack_v);
    irq_in  = in_v;
    mask    = mask_v;
    irq_ack = ack_v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_model("model");
  endtask

  typedef struct {
    logic [7:0] in_v;
    logic [7:0] mask_v;
    logic       ack;
    logic       req;
    logic [2:0] vec;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] i, input logic [7:0] m, input logic a,
                     input logic r, input logic [2:0] v, input logic [7:0] p);
    vec_t e;
    e.in_v = i; e.mask_v = m; e.ack = a; e.req = r; e.vec = v; e.pend = p;
    tbl.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // single event, latency 4 edges
    add(8'h04, 8'hFF, 0, 0, 0, 8'h00); add(8'h04, 8'hFF, 0, 0, 0, 8'h00);
    add(8'h04, 8'hFF, 0, 0, 0, 8'h04); add(8'h04, 8'hFF, 0, 1, 2, 8'h04);
    add(8'h04, 8'hFF, 1, 0, 2, 8'h00); add(8'h00, 8'hFF, 0, 0, 2, 8'h00);
    add(8'h00, 8'hFF, 0, 0, 2, 8'h00);
    // priority 7 then 0, ack held through release
    add(8'h81, 8'hFF, 0, 0, 2, 8'h00); add(8'h81, 8'hFF, 0, 0, 2, 8'h00);
    add(8'h81, 8'hFF, 0, 0, 2, 8'h81); add(8'h81, 8'hFF, 0, 1, 7, 8'h81);
    add(8'h81, 8'hFF, 1, 0, 7, 8'h01); add(8'h81, 8'hFF, 1, 0, 7, 8'h01);
    add(8'h81, 8'hFF, 0, 0, 7, 8'h01); add(8'h81, 8'hFF, 0, 1, 0, 8'h01);
    add(8'h81, 8'hFF, 1, 0, 0, 8'h00); add(8'h00, 8'hFF, 0, 0, 0, 8'h00);
    // masking defers, unmask presents, masking in REQ keeps request
    add(8'h20, 8'hDF, 0, 0, 0, 8'h00); add(8'h20, 8'hDF, 0, 0, 0, 8'h00);
    add(8'h20, 8'hDF, 0, 0, 0, 8'h20); add(8'h20, 8'hDF, 0, 0, 0, 8'h20);
    add(8'h20, 8'hDF, 0, 0, 0, 8'h20); add(8'h20, 8'hFF, 0, 1, 5, 8'h20);
    add(8'h20, 8'hDF, 0, 1, 5, 8'h20); add(8'h20, 8'hDF, 1, 0, 5, 8'h00);
    add(8'h00, 8'hFF, 0, 0, 5, 8'h00);
    // coalescing of a repeated rise
    add(8'h02, 8'h00, 0, 0, 5, 8'h00); add(8'h00, 8'h00, 0, 0, 5, 8'h00);
    add(8'h02, 8'h00, 0, 0, 5, 8'h02); add(8'h00, 8'h00, 0, 0, 5, 8'h02);
    add(8'h00, 8'h00, 0, 0, 5, 8'h02); add(8'h00, 8'hFF, 0, 1, 1, 8'h02);
    add(8'h00, 8'hFF, 1, 0, 1, 8'h00); add(8'h00, 8'hFF, 0, 0, 1, 8'h00);
    add(8'h00, 8'hFF, 0, 0, 1, 8'h00);
    // ack in IDLE is ignored
    add(8'h10, 8'h00, 1, 0, 1, 8'h00); add(8'h10, 8'h00, 1, 0, 1, 8'h00);
    add(8'h10, 8'h00, 1, 0, 1, 8'h10); add(8'h10, 8'h00, 1, 0, 1, 8'h10);
    add(8'h00, 8'hFF, 1, 1, 4, 8'h10); add(8'h00, 8'hFF, 1, 0, 4, 8'h00);
    add(8'h00, 8'hFF, 0, 0, 4, 8'h00);
    // set wins over clear on bit 3
    add(8'h08, 8'hFF, 0, 0, 4, 8'h00); add(8'h08, 8'hFF, 0, 0, 4, 8'h00);
    add(8'h08, 8'hFF, 0, 0, 4, 8'h08); add(8'h08, 8'hFF, 0, 1, 3, 8'h08);
    add(8'h00, 8'hFF, 0, 1, 3, 8'h08); add(8'h08, 8'hFF, 0, 1, 3, 8'h08);
    add(8'h08, 8'hFF, 0, 1, 3, 8'h08); add(8'h08, 8'hFF, 1, 0, 3, 8'h08);
    add(8'h08, 8'hFF, 0, 0, 3, 8'h08); add(8'h08, 8'hFF, 0, 1, 3, 8'h08);
    add(8'h08, 8'hFF, 1, 0, 3, 8'h00); add(8'h00, 8'hFF, 0, 0, 3, 8'h00);

    rst_n = 1'b0; irq_in = '0; mask = '0; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req",  {7'd0, irq_req}, 8'h00);
    chk("rst_vec",  {5'd0, irq_vec}, 8'h00);
    chk("rst_pend", pending, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].in_v, tbl[i].mask_v, tbl[i].ack);
      chk($sformatf("row%0d_req", i),  {7'd0, irq_req}, {7'd0, tbl[i].req});
      chk($sformatf("row%0d_vec", i),  {5'd0, irq_vec}, {5'd0, tbl[i].vec});
      chk($sformatf("row%0d_pend", i), pending, tbl[i].pend);
    end

    // Asynchronous reset in REQ, line held high through reset.
    repeat (4) cyc(8'h40, 8'hFF, 1'b0);
    chk("pre_rst_req", {7'd0, irq_req}, 8'h01);
    chk("pre_rst_vec", {5'd0, irq_vec}, 8'h06);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_req",  {7'd0, irq_req}, 8'h00);
    chk("async_rst_pend", pending, 8'h00);
    repeat (2) cyc(8'h40, 8'hFF, 1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(8'h40, 8'hFF, 1'b0);
    chk("held_high_pend", pending, 8'h40);
    chk("held_high_noreq", {7'd0, irq_req}, 8'h00);
    cyc(8'h40, 8'hFF, 1'b0);
    chk("held_high_req", {7'd0, irq_req}, 8'h01);
    chk("held_high_vec", {5'd0, irq_vec}, 8'h06);
    cyc(8'h40, 8'hFF, 1'b1);
    cyc(8'h00, 8'hFF, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [7:0] in_r, m_r;
      logic       a_r;
      in_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_in;
      m_r  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
      a_r  = ($urandom_range(0, 2) == 0);
      cyc(in_r, m_r, a_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
